frame_serialize: RTL and testbench

Transmit-side counterpart of the image byte-stream parser. It turns a frame header (height, width) and a stream of RGB pixels into the team's byte protocol:
- height, MSB first;
- width, MSB first;
- then R, G, B bytes per pixel, for height*width pixels.

It sits between the image source (frame buffer / pattern generator) and the byte transport (UART TX / FIFO), with valid/ready handshakes on both sides.

---
 rtl/image_stream_pkg.sv | 15 +
 rtl/frame_serialize_if.sv | 28 ++
 rtl/frame_serialize.sv | 151 +++++++++++++++
 tb/tb_frame_serialize.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_stream_pkg.sv
// Shared types and sizing for the image byte-stream protocol: header of
// height then width (MSB first), followed by R,G,B bytes per pixel.
package image_stream_pkg;

   localparam int DIM_W_DEFAULT = 16;
   localparam int HDR_BYTES     = 2 * DIM_W_DEFAULT / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PIX} state_e;
   typedef enum logic [1:0] {PH_R, PH_G, PH_B}        phase_e;

   function automatic int hdr_bytes(input int dim_w);
      return 2 * dim_w / 8;
   endfunction

endpackage

// File: rtl/frame_serialize_if.sv
// Frame request, pixel input and byte output handshakes of the serializer.
interface frame_serialize_if #(parameter int DIM_W = image_stream_pkg::DIM_W_DEFAULT);

   logic             start;
   logic [DIM_W-1:0] height;
   logic [DIM_W-1:0] width;
   logic [7:0]       pixel_r;
   logic [7:0]       pixel_g;
   logic [7:0]       pixel_b;
   logic             pixel_valid;
   logic             pixel_ready;
   logic [7:0]       data_out;
   logic             data_valid;
   logic             data_ready;
   logic             busy;
   logic             frame_done;

   modport master (
      output start, height, width, pixel_r, pixel_g, pixel_b, pixel_valid, data_ready,
      input  pixel_ready, data_out, data_valid, busy, frame_done
   );

   modport slave (
      input  start, height, width, pixel_r, pixel_g, pixel_b, pixel_valid, data_ready,
      output pixel_ready, data_out, data_valid, busy, frame_done
   );

endinterface

// File: rtl/frame_serialize.sv
// Serializes a (height, width) header and an RGB pixel stream into bytes.
// Header and pixel bytes share one registered output byte.
module frame_serialize
   import image_stream_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   frame_serialize_if.slave  bus
);

   localparam int HB    = hdr_bytes(DIM_W);
   localparam int IDX_W = $clog2(HB);
   localparam int TW    = 2 * DIM_W;

   state_e           state_q, state_d;
   phase_e           phase_q, phase_d;
   logic [TW-1:0]    hdr_q, hdr_d;
   logic [TW-1:0]    total_q, total_d;
   logic [TW-1:0]    pix_cnt_q, pix_cnt_d;
   logic [TW-1:0]    pix_cnt_inc;
   logic [IDX_W-1:0] hdr_idx_q, hdr_idx_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       g_q, g_d;
   logic [7:0]       b_q, b_d;
   logic             dvalid_q, dvalid_d;
   logic             done_q, done_d;
   logic             byte_acc, pix_acc, last_pix, pix_rdy;

   always_comb begin
      pix_cnt_inc = pix_cnt_q + TW'(1);
      last_pix    = (pix_cnt_inc == total_q);
      byte_acc    = dvalid_q & bus.data_ready;
      // A new pixel may ride on the B acceptance so the stream has no bubble.
      pix_rdy     = (state_q == ST_PIX) &&
                    (!dvalid_q || (phase_q == PH_B && bus.data_ready && !last_pix));
      pix_acc     = bus.pixel_valid & pix_rdy;
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      hdr_d     = hdr_q;
      total_d   = total_q;
      pix_cnt_d = pix_cnt_q;
      hdr_idx_d = hdr_idx_q;
      data_d    = data_q;
      g_d       = g_q;
      b_d       = b_q;
      dvalid_d  = dvalid_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               hdr_d     = {bus.height, bus.width};
               total_d   = TW'(bus.height) * TW'(bus.width);
               data_d    = bus.height[DIM_W-1 -: 8];
               dvalid_d  = 1'b1;
               hdr_idx_d = '0;
               state_d   = ST_HDR;
            end
         end
         ST_HDR: begin
            if (byte_acc) begin
               if (hdr_idx_q == IDX_W'(HB - 1)) begin
                  dvalid_d = 1'b0;
                  if (total_q == '0) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     pix_cnt_d = '0;
                     state_d   = ST_PIX;
                  end
               end else begin
                  // hdr_q is shifted left so the next byte always sits just below the top.
                  hdr_idx_d = hdr_idx_q + IDX_W'(1);
                  data_d    = hdr_q[TW-9 -: 8];
                  hdr_d     = hdr_q << 8;
               end
            end
         end
         ST_PIX: begin
            if (byte_acc) begin
               case (phase_q)
                  PH_R: begin
                     data_d  = g_q;
                     phase_d = PH_G;
                  end
                  PH_G: begin
                     data_d  = b_q;
                     phase_d = PH_B;
                  end
                  default: begin
                     pix_cnt_d = pix_cnt_inc;
                     dvalid_d  = 1'b0;
                     if (last_pix) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end
               endcase
            end
            if (pix_acc) begin
               data_d   = bus.pixel_r;
               g_d      = bus.pixel_g;
               b_d      = bus.pixel_b;
               phase_d  = PH_R;
               dvalid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_R;
         hdr_q     <= '0;
         total_q   <= '0;
         pix_cnt_q <= '0;
         hdr_idx_q <= '0;
         data_q    <= '0;
         g_q       <= '0;
         b_q       <= '0;
         dvalid_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         hdr_q     <= hdr_d;
         total_q   <= total_d;
         pix_cnt_q <= pix_cnt_d;
         hdr_idx_q <= hdr_idx_d;
         data_q    <= data_d;
         g_q       <= g_d;
         b_q       <= b_d;
         dvalid_q  <= dvalid_d;
         done_q    <= done_d;
      end
   end

   assign bus.pixel_ready = pix_rdy;
   assign bus.data_out    = data_q;
   assign bus.data_valid  = dvalid_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_frame_serialize.sv
// Scoreboard bench: frames are turned into expected byte lists up front and a
// monitor compares every accepted byte and frame_done pulse against them.
module tb_frame_serialize;
   import image_stream_pkg::*;

   localparam int DIM_W = 16;
   localparam int HB    = 2 * DIM_W / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   frame_serialize_if #(.DIM_W(DIM_W)) bus();
   frame_serialize #(.DIM_W(DIM_W)) dut (.clk(clk), .reset(rst_n), .bus(bus));

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [23:0] pix_q[$];
   int          exp_done = 0;
   int          rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random
   int          pix_pct  = 100;
   bit          pr_seen;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: header bytes of {h,w} MSB first, then r,g,b per pixel.
   task automatic push_frame(input logic [DIM_W-1:0] h, input logic [DIM_W-1:0] w, input bit seq_pix);
      logic [2*DIM_W-1:0] hdr;
      int n;
      logic [7:0] r, g, b;
      hdr = {h, w};
      n   = int'(h) * int'(w);
      for (int i = 0; i < HB; i++)
         exp_q.push_back(8'((hdr >> (8 * (HB - 1 - i))) & 'hff));
      for (int i = 1; i <= n; i++) begin
         if (seq_pix) begin
            r = 8'(i); g = 8'(i + 1); b = 8'(i + 2);
         end else begin
            {r, g, b} = 24'($urandom);
         end
         pix_q.push_back({r, g, b});
         exp_q.push_back(r);
         exp_q.push_back(g);
         exp_q.push_back(b);
      end
      exp_done++;
   endtask

   task automatic issue_start(input logic [DIM_W-1:0] h, input logic [DIM_W-1:0] w);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.height = h;
      bus.width  = w;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.height = DIM_W'($urandom);
      bus.width  = DIM_W'($urandom);
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (bus.frame_done) break;
         if (cyc >= budget) begin
            checks++; errors++;
            $display("FAIL wait_done: no frame_done within %0d cycles", budget);
            break;
         end
      end
   endtask

   task automatic finish_frame(input string name, input int exp_cyc);
      int cyc;
      wait_done(3000, cyc);
      if (exp_cyc >= 0) chk({name, "_latency"}, cyc, exp_cyc);
      chk({name, "_busy_at_done"}, bus.busy, 0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, bus.frame_done, 0);
      chk({name, "_exp_drained"}, exp_q.size(), 0);
      chk({name, "_done_count"}, exp_done, 0);
   endtask

   task automatic poll_exp(input int size, input int budget);
      int k;
      k = 0;
      while (1) begin
         @(posedge clk); #3;
         if (exp_q.size() == size) break;
         k++;
         if (k >= budget) begin
            checks++; errors++;
            $display("FAIL poll_exp: queue size %0d never reached %0d", exp_q.size(), size);
            break;
         end
      end
   endtask

   initial begin
      bus.data_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       bus.data_ready = 1'b1;
            1:       bus.data_ready = ~bus.data_ready;
            default: bus.data_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Pixel source: offers the head of pix_q, pops it after a handshake.
   initial begin
      bit take;
      bus.pixel_valid = 1'b0;
      bus.pixel_r = '0; bus.pixel_g = '0; bus.pixel_b = '0;
      forever begin
         @(negedge clk);
         take = bus.pixel_valid && bus.pixel_ready;
         @(posedge clk);
         if (take && pix_q.size() > 0) void'(pix_q.pop_front());
         #1;
         if (pix_q.size() > 0 && $urandom_range(0, 99) < pix_pct) begin
            bus.pixel_valid = 1'b1;
            {bus.pixel_r, bus.pixel_g, bus.pixel_b} = pix_q[0];
         end else begin
            bus.pixel_valid = 1'b0;
         end
      end
   end

   initial begin
      bit         hold;
      logic [7:0] held;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            chk("hold_valid", bus.data_valid, 1);
            chk("hold_data", bus.data_out, held);
         end
         if (bus.pixel_ready) begin
            pr_seen = 1'b1;
            chk("pixrdy_busy", bus.busy, 1);
         end
         if (bus.data_valid && bus.data_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_byte: got %0h expected no byte", bus.data_out);
            end else begin
               chk("byte", bus.data_out, exp_q.pop_front());
            end
         end
         if (bus.frame_done) begin
            chk("done_expected", exp_done > 0, 1);
            chk("done_all_bytes", exp_q.size(), 0);
            if (exp_done > 0) exp_done--;
         end
         hold = bus.data_valid && !bus.data_ready;
         held = bus.data_out;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] px;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.height = '0;
      bus.width  = '0;
      #1;
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_data_valid", bus.data_valid, 0);
      chk("rst_pixel_ready", bus.pixel_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // 2x3 frame, both sides always ready: 1 byte/clk after the first pixel
      rdy_mode = 0; pix_pct = 100;
      repeat (2) @(posedge clk);
      push_frame(16'd2, 16'd3, 1'b1);
      issue_start(16'd2, 16'd3);
      finish_frame("t1", 2 + HB + 3 * 6);

      // same frame with data_ready toggling
      rdy_mode = 1;
      push_frame(16'd2, 16'd3, 1'b1);
      issue_start(16'd2, 16'd3);
      finish_frame("t2", -1);

      // zero-height frame: header only, pixels left untouched
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      pix_q.push_back(24'hAABBCC);
      pix_q.push_back(24'h112233);
      pr_seen = 1'b0;
      push_frame(16'd0, 16'd5, 1'b1);
      issue_start(16'd0, 16'd5);
      finish_frame("t3", HB + 1);
      chk("t3_pixel_ready_seen", pr_seen, 0);
      chk("t3_pixels_untouched", pix_q.size(), 2);
      pix_q.delete();
      repeat (2) @(posedge clk);

      // 1x1 frame with the pixel arriving late
      push_frame(16'd1, 16'd1, 1'b0);
      px = pix_q.pop_front();
      issue_start(16'd1, 16'd1);
      poll_exp(3, 50);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_gap_valid", bus.data_valid, 0);
         chk("t4_gap_busy", bus.busy, 1);
      end
      pix_q.push_back(px);
      finish_frame("t4", -1);

      // reset after the G byte of the first pixel
      push_frame(16'd1, 16'd2, 1'b1);
      issue_start(16'd1, 16'd2);
      poll_exp(4, 50);
      rst_n = 1'b0;
      #1;
      chk("t5_data_out", bus.data_out, 0);
      chk("t5_data_valid", bus.data_valid, 0);
      chk("t5_pixel_ready", bus.pixel_ready, 0);
      chk("t5_busy", bus.busy, 0);
      chk("t5_frame_done", bus.frame_done, 0);
      exp_q.delete();
      pix_q.delete();
      exp_done = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      push_frame(16'd3, 16'd1, 1'b0);
      issue_start(16'd3, 16'd1);
      finish_frame("t5_fresh", 2 + HB + 3 * 3);

      // start pulsed while busy with other dimensions
      rdy_mode = 2; pix_pct = 70;
      push_frame(16'd2, 16'd2, 1'b0);
      issue_start(16'd2, 16'd2);
      bus.start = 1'b1; bus.height = 16'd7; bus.width = 16'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      finish_frame("t6", -1);
      repeat (3) begin
         @(negedge clk);
         chk("t6_stays_idle", bus.busy, 0);
      end

      // random frames with random backpressure on both sides
      for (int f = 0; f < 8; f++) begin
         logic [DIM_W-1:0] h, w;
         h = DIM_W'($urandom_range(0, 4));
         w = DIM_W'($urandom_range(0, 4));
         rdy_mode = $urandom_range(0, 2);
         pix_pct  = $urandom_range(30, 100);
         push_frame(h, w, 1'b0);
         issue_start(h, w);
         finish_frame("rand", -1);
      end

      chk("final_exp_empty", exp_q.size(), 0);
      chk("final_pix_empty", pix_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
